fnd_time_display: RTL and testbench

// - Consumer of the time-of-day counter outputs (hour/min/sec/centisecond fields): renders them on a 4-digit multiplexed 7-segment FND.
// - Scans one digit per scan tick and shows HH.MM or SS.cc, selected by a mode button.
// - Captures all four fields once per scan frame, so every frame shows one consistent time.
// - Sits between the time counter and the board FND pins.

---
 rtl/fnd_pkg.sv | 35 +++
 rtl/fnd_font_decoder.sv | 32 +++
 rtl/fnd_time_display.sv | 103 ++++++++++
 tb/tb_fnd_time_display.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the multiplexed 7-segment time display.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}, with dp off.
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] COM_OFF   = 4'b1111;

  // Largest value that still fits on two decimal digits.
  localparam logic [6:0] FIELD_MAX = 7'd99;

  typedef enum logic {
    MODE_HHMM = 1'b0,
    MODE_SSCC = 1'b1
  } mode_e;

  typedef struct packed {
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [6:0] ms;
  } time_snap_t;

endpackage

// File: rtl/fnd_font_decoder.sv
// Decimal digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; dash overrides the digit.
// Purely combinational; codes above 9 render blank.
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK[6:0];
    if (dash) begin
      seg = SEG_DASH[6:0];
    end else begin
      case (digit)
        4'd0:    seg = SEG_0[6:0];
        4'd1:    seg = SEG_1[6:0];
        4'd2:    seg = SEG_2[6:0];
        4'd3:    seg = SEG_3[6:0];
        4'd4:    seg = SEG_4[6:0];
        4'd5:    seg = SEG_5[6:0];
        4'd6:    seg = SEG_6[6:0];
        4'd7:    seg = SEG_7[6:0];
        4'd8:    seg = SEG_8[6:0];
        4'd9:    seg = SEG_9[6:0];
        default: seg = SEG_BLANK[6:0];
      endcase
    end
  end

endmodule

// File: rtl/fnd_time_display.sv
// Scans a 4-digit FND showing HH.MM or SS.cc from a per-frame snapshot of the time fields.
// Outputs registered, 1 cycle behind digit_idx/mode/snapshot; no backpressure, free-running scan.
module fnd_time_display
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [6:0] i_ms,
  input  logic       i_mode,
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_font
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       digit_idx;
  mode_e            mode;
  mode_e            mode_pend;
  mode_e            mode_pend_nxt;
  logic             btn_q;
  time_snap_t       snapshot;

  logic             tick;
  logic             frame_end;
  logic             btn_rise;

  logic [6:0]       field_val;
  logic [3:0]       digit_val;
  logic             field_dash;
  logic             dp_on;
  logic [6:0]       seg;
  logic [3:0]       com_nxt;
  logic [7:0]       font_nxt;

  assign tick      = (scan_cnt == CNT_LAST);
  assign frame_end = tick && (digit_idx == 2'd3);
  assign btn_rise  = i_mode && !btn_q;

  // A press landing on the frame boundary edge is applied at that same boundary.
  assign mode_pend_nxt = btn_rise ? mode_e'(~mode_pend) : mode_pend;

  always_comb begin
    field_val = 7'd0;
    if (digit_idx[1]) begin
      field_val = (mode == MODE_SSCC) ? {1'b0, snapshot.sec} : {1'b0, snapshot.hour};
    end else begin
      field_val = (mode == MODE_SSCC) ? snapshot.ms : {1'b0, snapshot.min};
    end
  end

  // Odd digit positions carry the tens, even positions the ones.
  always_comb begin
    field_dash = (field_val > FIELD_MAX);
    digit_val  = digit_idx[0] ? 4'(field_val / 7'd10) : 4'(field_val % 7'd10);
  end

  fnd_font_decoder u_font_decoder (
    .digit (digit_val),
    .dash  (field_dash),
    .seg   (seg)
  );

  // dp sits on digit 2 only; in HH.MM it blinks with the seconds LSB.
  always_comb begin
    dp_on    = (digit_idx == 2'd2) && ((mode == MODE_SSCC) || !snapshot.sec[0]);
    com_nxt  = ~(4'b0001 << digit_idx);
    font_nxt = {~dp_on, seg};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      scan_cnt   <= '0;
      digit_idx  <= 2'd0;
      mode       <= MODE_HHMM;
      mode_pend  <= MODE_HHMM;
      btn_q      <= 1'b0;
      snapshot   <= '0;
      o_fnd_com  <= COM_OFF;
      o_fnd_font <= SEG_BLANK;
    end else begin
      scan_cnt  <= tick ? '0 : scan_cnt + CNT_W'(1);
      if (tick) begin
        digit_idx <= digit_idx + 2'd1;
      end
      btn_q     <= i_mode;
      mode_pend <= mode_pend_nxt;
      if (frame_end) begin
        snapshot <= {i_hour, i_min, i_sec, i_ms};
        mode     <= mode_pend_nxt;
      end
      o_fnd_com  <= com_nxt;
      o_fnd_font <= font_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_time_display.sv
// Bench for fnd_time_display: directed scenarios plus random stimulus, checked every cycle
// against a frame-level reference model of what the display should show.
module tb_fnd_time_display;

  localparam int D = 4;
  localparam int FRAME = 4 * D;

  logic       clk;
  logic       rst;
  logic [5:0] hour;
  logic [5:0] mins;
  logic [5:0] sec;
  logic [6:0] ms;
  logic       mode_in;
  logic [3:0] com;
  logic [7:0] font;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset, time shown in the current frame, mode state.
  int n;
  int m_h, m_m, m_s, m_ms;
  int m_mode, m_pend, prev_btn;

  logic [7:0] font_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [7:0] frame_font [4];
  logic [3:0] frame_com  [4];

  fnd_time_display #(.SCAN_DIV(D)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_hour     (hour),
    .i_min      (mins),
    .i_sec      (sec),
    .i_ms       (ms),
    .i_mode     (mode_in),
    .o_fnd_com  (com),
    .o_fnd_font (font)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  function automatic logic [7:0] exp_font(input int dig);
    int v;
    logic [7:0] f;
    if (dig >= 2) v = (m_mode != 0) ? m_s : m_h;
    else          v = (m_mode != 0) ? m_ms : m_m;
    if (v > 99) f = 8'hBF;
    else        f = font_tbl[(dig % 2 == 1) ? v / 10 : v % 10];
    if (dig == 2 && (m_mode != 0 || m_s % 2 == 0)) f[7] = 1'b0;
    return f;
  endfunction

  // One clock edge: predict the outputs from the model state before the edge,
  // then advance the model with the inputs that were present at the edge.
  task automatic step();
    int h, mi, s, c, md, r, dig;
    logic [3:0] ecom;
    logic [7:0] efont;
    h = int'(hour); mi = int'(mins); s = int'(sec); c = int'(ms);
    md = int'(mode_in); r = int'(rst);
    @(posedge clk);
    #1;
    if (r != 0) begin
      ecom = 4'hF;
      efont = 8'hFF;
      n = 0;
      m_h = 0; m_m = 0; m_s = 0; m_ms = 0;
      m_mode = 0; m_pend = 0; prev_btn = 0;
    end else begin
      n++;
      dig = ((n - 1) / D) % 4;
      ecom = ~(4'b0001 << dig);
      efont = exp_font(dig);
      if (md != 0 && prev_btn == 0) m_pend = 1 - m_pend;
      prev_btn = md;
      if (n % FRAME == 0) begin
        m_h = h; m_m = mi; m_s = s; m_ms = c;
        m_mode = m_pend;
      end
    end
    chk("com", {4'h0, com}, {4'h0, ecom});
    chk("font", font, efont);
  endtask

  task automatic run_steps(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      step();
      if (n > 0 && (n - 1) % D == 0) begin
        frame_font[((n - 1) / D) % 4] = font;
        frame_com[((n - 1) / D) % 4]  = com;
      end
    end
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] d3, input logic [7:0] d2,
                           input logic [7:0] d1, input logic [7:0] d0);
    chk({tag, "_d3"}, frame_font[3], d3);
    chk({tag, "_d2"}, frame_font[2], d2);
    chk({tag, "_d1"}, frame_font[1], d1);
    chk({tag, "_d0"}, frame_font[0], d0);
  endtask

  initial begin
    n = 0;
    m_h = 0; m_m = 0; m_s = 0; m_ms = 0;
    m_mode = 0; m_pend = 0; prev_btn = 0;
    hour = 6'd13; mins = 6'd45; sec = 6'd7; ms = 7'd89; mode_in = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("reset_com", {4'h0, com}, 8'h0F);
    chk("reset_font", font, 8'hFF);
    rst = 1'b0;

    // Frame 0 shows the cleared snapshot; com walks E,D,B,7.
    run_steps(FRAME);
    chk_frame("f0", 8'hC0, 8'h40, 8'hC0, 8'hC0);
    chk("f0_com0", {4'h0, frame_com[0]}, 8'h0E);
    chk("f0_com1", {4'h0, frame_com[1]}, 8'h0D);
    chk("f0_com2", {4'h0, frame_com[2]}, 8'h0B);
    chk("f0_com3", {4'h0, frame_com[3]}, 8'h07);

    // Frame 1: 13.45 with odd seconds, dp off; seconds go even mid-frame.
    run_steps(8);
    sec = 6'd8;
    run_steps(8);
    chk_frame("f1", 8'hF9, 8'hB0, 8'h99, 8'h92);

    // Frame 2: even seconds light dp on digit 2.
    run_steps(FRAME);
    chk_frame("f2", 8'hF9, 8'h30, 8'h99, 8'h92);

    // Frame 3: mode pressed mid-frame, rest of frame stays HH.MM.
    run_steps(6);
    mode_in = 1'b1;
    sec = 6'd7;
    run_steps(2);
    mode_in = 1'b0;
    run_steps(8);
    chk_frame("f3", 8'hF9, 8'h30, 8'h99, 8'h92);

    // Frames 4 and 5: SS.cc 07.89 with steady dp; second press in frame 5.
    run_steps(FRAME);
    chk_frame("f4", 8'hC0, 8'h78, 8'h80, 8'h90);
    run_steps(4);
    mode_in = 1'b1;
    run_steps(1);
    mode_in = 1'b0;
    run_steps(11);
    chk_frame("f5", 8'hC0, 8'h78, 8'h80, 8'h90);

    // Frame 6: minutes change while digit 1 is lit; frame keeps 45.
    run_steps(5);
    mins = 6'd46;
    run_steps(11);
    chk_frame("f6", 8'hF9, 8'hB0, 8'h99, 8'h92);
    run_steps(FRAME);
    chk_frame("f7", 8'hF9, 8'hB0, 8'h99, 8'h82);

    // Frame 9: out-of-range centiseconds in SS.cc show dashes.
    run_steps(4);
    mode_in = 1'b1;
    ms = 7'd120;
    run_steps(1);
    mode_in = 1'b0;
    run_steps(11);
    run_steps(FRAME);
    chk_frame("f9", 8'hC0, 8'h78, 8'hBF, 8'hBF);

    // Press on the exact boundary edge takes effect for the very next frame.
    run_steps(FRAME - 1);
    mode_in = 1'b1;
    run_steps(1);
    mode_in = 1'b0;
    run_steps(FRAME);
    chk_frame("f11", 8'hF9, 8'hB0, 8'h99, 8'h82);

    // Reset while digit 2 is lit: dark for one cycle, then 00.00 from digit 0.
    run_steps(9);
    chk("mid_com", {4'h0, com}, 8'h0B);
    rst = 1'b1;
    step();
    chk("mid_rst_com", {4'h0, com}, 8'h0F);
    chk("mid_rst_font", font, 8'hFF);
    rst = 1'b0;
    run_steps(FRAME);
    chk_frame("r0", 8'hC0, 8'h40, 8'hC0, 8'hC0);
    chk("r0_com0", {4'h0, frame_com[0]}, 8'h0E);

    // Random fields, button activity and occasional resets.
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        hour = 6'($urandom_range(0, 63));
        mins = 6'($urandom_range(0, 63));
        sec  = 6'($urandom_range(0, 63));
        ms   = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 19) == 0) mode_in = ~mode_in;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    mode_in = 1'b0;
    run_steps(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
